issue_select: RTL
=================

Name: issue_select

Overview:
- Consumer side of the 8-entry issue queue.
- Watches the queue's per-slot snapshot and selects up to two operand-ready entries per cycle, oldest first.
- Drives the queue's pop0/pop_key0 and pop1/pop_key1 strobes.
- Registers the selected entries onto two execution-port outputs.
- Owns the register-ready scoreboard, which is updated by dispatch and writeback.

Parameters:
- ENTRY_W, 32: entry width; matches the queue entry size.
- NUM_PREG, 64: physical registers tracked by the scoreboard. Tags are 6 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  pipeline flush
- iq_data  in  8*ENTRY_W  slot snapshot, slot i at [i*ENTRY_W +: ENTRY_W]; zero when the slot is invalid
- iq_vld  in  8  per-slot valid
- pop0  out  1  pop strobe, port 0 (combinational)
- pop_key0  out  3  slot index, port 0
- pop1  out  1  pop strobe, port 1 (combinational)
- pop_key1  out  3  slot index, port 1
- disp_vld  in  2  dispatch lanes writing a destination
- disp_dst  in  12  two 6-bit dispatch destination tags
- wb_vld  in  2  writeback lanes
- wb_tag  in  12  two 6-bit writeback tags
- ex_stall  in  1  execution back-pressure
- ex_vld  out  2  issued-entry valid, per port
- ex_data0  out  ENTRY_W  entry issued on port 0
- ex_data1  out  ENTRY_W  entry issued on port 1

Behaviour:
- Entry fields:
  - [5:0] dst
  - [11:6] src0
  - [17:12] src1
  - [18] src0_used
  - [19] src1_used
  - remaining bits opaque
- Scoreboard: NUM_PREG ready bits.
  - Reset and flush set all bits to 1.
  - disp_vld[k] clears bit disp_dst[k] at the clock edge.
  - wb_vld[k] sets bit wb_tag[k] at the clock edge.
  - If a tag is both cleared and set in the same cycle, the clear wins; dispatch is newer.
- Ready(i) = iq_vld[i] AND (!src0_used OR rdy[src0]) AND (!src1_used OR rdy[src1]).
- Age matrix: older[i][j] means slot i is older than slot j. A slot is newly allocated when iq_vld[i]=1 and prev_vld[i]=0.
  - On allocation of slot i: older[i][*] is cleared and older[*][i] is set for every valid, non-new slot.
  - Two slots allocated in the same cycle: the lower index is older.
  - prev_vld is reset to 0 and cleared on flush.
- Select, combinational from the current snapshot:
  - Port 0 takes the ready slot with no older ready slot.
  - Port 1 takes the oldest remaining ready slot.
  - pop0/pop1 are asserted only when the corresponding slot exists AND ex_stall=0 AND flush=0. pop1 requires pop0.
  - pop_key0 is never equal to pop_key1 while pop1=1.
  - pop_key values are 0 when the matching pop is low.
- Output registers:
  - When ex_stall=0: ex_vld <= {pop1, pop0}; ex_dataN <= selected entry, or 0 when not selected.
  - When ex_stall=1: outputs hold and no pops are made.
  - Latency: entry visible in the snapshot at cycle t appears on ex_* at cycle t+1.
- Reset (rst_n=0 at an edge): ex_vld=0, ex_data0/1=0, scoreboard all ready, age matrix and prev_vld cleared.
- Flush: same as reset. pop0/pop1 are forced low in the flush cycle.
- The block does not rely on queue-side checking; it must never pop an invalid slot.
- An empty queue (iq_vld=0) produces no pops and ex_vld=0 on the next unstalled edge.

Optional Feature:
- Macro ISSUE_SEL_BYPASS_EN.
- Defined: a writeback tag in the current cycle counts as ready for Ready(i) in that same cycle (wakeup bypass).
- Undefined: a writeback becomes visible one cycle after the wb edge.

Test Plan:
- Reset, then iq_vld=8'h05 with slots 0 and 2 having no used sources -> pop0=1, pop_key0=0, pop1=1, pop_key1=2; next cycle ex_vld=2'b11, ex_data0=slot0, ex_data1=slot2.
- Slot 5 allocated before slot 1, both ready -> pop_key0=5, pop_key1=1.
- disp_vld=2'b01 with disp_dst=7; slot 3 with src0_used=1, src0=7 -> no pop. Assert wb_tag=7 -> pop_key0=3 one cycle later without the macro, same cycle with ISSUE_SEL_BYPASS_EN.
- Ready entries present and ex_stall=1 for 3 cycles -> pops stay 0 and ex_* hold; stall released -> pops resume.
- flush=1 while ex_vld=2'b11 -> pops low that cycle; next cycle ex_vld=0 and scoreboard reads all ready.
- rst_n=0 mid-stream -> ex_vld=0 and ex_data=0 at the next edge; the age order restarts from slot index.

Source files
------------

// File: rtl/issue_select.sv
// issue_select: oldest-first dual issue from the 8-slot issue queue with register-ready scoreboard.
// Optional ISSUE_SEL_BYPASS_EN: same-cycle writeback wakeup bypass.
module issue_select #(
    parameter int ENTRY_W  = 32,
    parameter int NUM_PREG = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [8*ENTRY_W-1:0] iq_data,
    input  logic [7:0]           iq_vld,
    output logic                 pop0,
    output logic [2:0]           pop_key0,
    output logic                 pop1,
    output logic [2:0]           pop_key1,
    input  logic [1:0]           disp_vld,
    input  logic [11:0]          disp_dst,
    input  logic [1:0]           wb_vld,
    input  logic [11:0]          wb_tag,
    input  logic                 ex_stall,
    output logic [1:0]           ex_vld,
    output logic [ENTRY_W-1:0]   ex_data0,
    output logic [ENTRY_W-1:0]   ex_data1
);
    logic [NUM_PREG-1:0] rdy_q, rdy_d, wb_set, disp_clr, rdy_eff;
    logic [7:0]          prev_vld_q, is_new, ready, sel0, sel1, rem;
    logic [7:0]          older_q [8];
    logic [7:0]          older_d [8];
    logic [ENTRY_W-1:0]  ent [8];
    logic [2:0]          k0, k1;
    logic                go;
    logic [1:0]          ex_vld_q;
    logic [ENTRY_W-1:0]  ex_d0_q, ex_d1_q;

    always_comb begin
        wb_set   = '0;
        disp_clr = '0;
        for (int k = 0; k < 2; k++) begin
            if (wb_vld[k]) wb_set[wb_tag[k*6 +: 6]] = 1'b1;
            if (disp_vld[k]) disp_clr[disp_dst[k*6 +: 6]] = 1'b1;
        end
        rdy_d = (rdy_q | wb_set) & ~disp_clr;
    end

`ifdef ISSUE_SEL_BYPASS_EN
    assign rdy_eff = rdy_q | wb_set;
`else
    assign rdy_eff = rdy_q;
`endif

    // Selection uses the post-allocation age matrix so fresh slots can issue in their first cycle.
    always_comb begin
        is_new = iq_vld & ~prev_vld_q;
        for (int i = 0; i < 8; i++) begin
            ent[i]   = iq_data[i*ENTRY_W +: ENTRY_W];
            ready[i] = iq_vld[i] & (!ent[i][18] | rdy_eff[ent[i][11:6]])
                                 & (!ent[i][19] | rdy_eff[ent[i][17:12]]);
            for (int j = 0; j < 8; j++)
                older_d[i][j] = is_new[i] ? (is_new[j] && j > i)
                              : is_new[j] ? iq_vld[i] : older_q[i][j];
        end
    end

    always_comb begin
        sel0 = ready;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (ready[j] && older_d[j][i]) sel0[i] = 1'b0;
        k0 = '0;
        for (int i = 7; i >= 0; i--)
            if (sel0[i]) k0 = 3'(i);
        rem     = ready;
        rem[k0] = 1'b0;
        sel1    = rem;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (rem[j] && older_d[j][i]) sel1[i] = 1'b0;
        k1 = '0;
        for (int i = 7; i >= 0; i--)
            if (sel1[i]) k1 = 3'(i);
        go       = rst_n && !flush && !ex_stall;
        pop0     = go && |sel0;
        pop1     = pop0 && |sel1;
        pop_key0 = pop0 ? k0 : 3'd0;
        pop_key1 = pop1 ? k1 : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rdy_q      <= '1;
            prev_vld_q <= '0;
            ex_vld_q   <= '0;
            ex_d0_q    <= '0;
            ex_d1_q    <= '0;
            for (int i = 0; i < 8; i++) older_q[i] <= '0;
        end else begin
            rdy_q      <= rdy_d;
            prev_vld_q <= iq_vld;
            older_q    <= older_d;
            if (!ex_stall) begin
                ex_vld_q <= {pop1, pop0};
                ex_d0_q  <= pop0 ? ent[k0] : '0;
                ex_d1_q  <= pop1 ? ent[k1] : '0;
            end
        end
    end

    assign ex_vld   = ex_vld_q;
    assign ex_data0 = ex_d0_q;
    assign ex_data1 = ex_d1_q;
endmodule
